// File: rtl/seq_div.sv
// rtl/seq_div.sv - sequential restoring divider, signed/unsigned, valid/ready handshake
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands and is_signed valid this cycle
//   in_ready   divider can accept operands (IDLE only)
//   a, b       dividend, divisor
//   is_signed  1 = two's-complement operands, 0 = unsigned
//   flush      synchronous abort of any operation in flight
//   out_valid  quotient/remainder valid (DONE only)
//   out_ready  consumer accepts result
//   quotient   a / b truncated toward zero (all ones when b == 0)
//   remainder  a - b*quotient, sign follows a (a when b == 0)
module seq_div #(
    parameter int div_size = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [div_size-1:0] a,
    input  logic [div_size-1:0] b,
    input  logic                is_signed,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [div_size-1:0] quotient,
    output logic [div_size-1:0] remainder
);

    localparam int CW = (div_size > 1) ? $clog2(div_size) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]       cnt;
    logic [div_size-1:0] dvd;       // dividend magnitude, shifts out MSB-first and fills with quotient bits
    logic [div_size-1:0] dvsr;      // divisor magnitude
    logic [div_size-1:0] part_rem;  // partial remainder, always < dvsr so it fits div_size bits
    logic                q_neg;
    logic                r_neg;

    logic                div_zero;
    logic                sig_ovf;
    logic                last_step;
    logic [div_size-1:0] a_mag;
    logic [div_size-1:0] b_mag;

    logic [div_size:0]   r_shift;
    logic [div_size:0]   diff;
    logic                q_bit;
    logic [div_size-1:0] r_next;
    logic [div_size-1:0] dvd_next;
    logic [div_size-1:0] q_fix;
    logic [div_size-1:0] r_fix;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign div_zero  = (b == '0);
    // Most-negative / -1 overflows the magnitude datapath's sign fix-up, so it is short-circuited.
    assign sig_ovf   = is_signed && (a == {1'b1, {(div_size-1){1'b0}}}) && (b == '1);
    assign last_step = (cnt == CW'(div_size - 1));

    // Negating the most negative value yields the same bit pattern, which is its correct unsigned magnitude.
    assign a_mag = (is_signed && a[div_size-1]) ? -a : a;
    assign b_mag = (is_signed && b[div_size-1]) ? -b : b;

    // One restoring step: shift in next dividend bit, trial-subtract, keep on non-negative result.
    always_comb begin
        r_shift  = {part_rem, dvd[div_size-1]};
        diff     = r_shift - {1'b0, dvsr};
        q_bit    = ~diff[div_size];
        r_next   = q_bit ? diff[div_size-1:0] : r_shift[div_size-1:0];
        dvd_next = {dvd[div_size-2:0], q_bit};
        q_fix    = q_neg ? -dvd_next : dvd_next;
        r_fix    = r_neg ? -r_next : r_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state_next = (div_zero || sig_ovf) ? DONE : CALC;
                    end
                end
                CALC: begin
                    if (last_step) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            dvd       <= '0;
            dvsr      <= '0;
            part_rem  <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt <= '0;
                        if (div_zero) begin
                            quotient  <= '1;
                            remainder <= a;
                        end else if (sig_ovf) begin
                            quotient  <= a;
                            remainder <= '0;
                        end else begin
                            dvd      <= a_mag;
                            dvsr     <= b_mag;
                            part_rem <= '0;
                            q_neg    <= is_signed && (a[div_size-1] ^ b[div_size-1]);
                            r_neg    <= is_signed && a[div_size-1];
                        end
                    end
                end
                CALC: begin
                    dvd      <= dvd_next;
                    part_rem <= r_next;
                    if (last_step) begin
                        cnt       <= '0;
                        quotient  <= q_fix;
                        remainder <= r_fix;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// tb/tb_seq_div.sv - self-checking bench for seq_div with an arithmetic reference model
module tb_seq_div;

    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          is_signed;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [DW-1:0] remainder;

    int total;
    int bad;

    seq_div #(.div_size(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division (truncates toward zero, remainder follows dividend).
    function automatic void model(input logic [DW-1:0] ma, input logic [DW-1:0] mb, input logic ms,
                                  output logic [DW-1:0] q, output logic [DW-1:0] r, output int lat);
        int sa;
        int sb;
        if (mb == 0) begin
            q = '1;
            r = ma;
            lat = 1;
        end else if (ms) begin
            sa = int'($signed(ma));
            sb = int'($signed(mb));
            if (sa == -128 && sb == -1) begin
                q = ma;
                r = '0;
                lat = 1;
            end else begin
                q = DW'(sa / sb);
                r = DW'(sa % sb);
                lat = DW + 1;
            end
        end else begin
            q = ma / mb;
            r = ma % mb;
            lat = DW + 1;
        end
    endfunction

    // Drives one operation; lat counts cycles after the acceptance edge until out_valid (-1 on timeout).
    task automatic run_op(input logic [DW-1:0] ta, input logic [DW-1:0] tb_, input logic ts,
                          output logic [DW-1:0] q, output logic [DW-1:0] r, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        a = ta;
        b = tb_;
        is_signed = ts;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = DW'($urandom_range(255));
        b = DW'($urandom_range(255));
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        q = quotient;
        r = remainder;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [DW-1:0] ta, input logic [DW-1:0] tb_,
                            input logic ts);
        logic [DW-1:0] q, r, eq, er;
        int lat, elat;
        model(ta, tb_, ts, eq, er, elat);
        run_op(ta, tb_, ts, q, r, lat);
        total++;
        if (lat !== elat) begin
            bad++;
            $display("FAIL %s latency a=%h b=%h s=%0d: got %0d expected %0d", name, ta, tb_, ts, lat, elat);
        end
        total++;
        if (q !== eq) begin
            bad++;
            $display("FAIL %s quotient a=%h b=%h s=%0d: got %h expected %h", name, ta, tb_, ts, q, eq);
        end
        total++;
        if (r !== er) begin
            bad++;
            $display("FAIL %s remainder a=%h b=%h s=%0d: got %h expected %h", name, ta, tb_, ts, r, er);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #13;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        total++;
        if (quotient !== '0) begin bad++; $display("FAIL reset_quotient: got %h expected 00", quotient); end
        total++;
        if (remainder !== '0) begin bad++; $display("FAIL reset_remainder: got %h expected 00", remainder); end
        @(negedge clk);
        rst_n = 1'b1;
        // First edge after release must accept: latency check proves it.
        check_op("reset_first_accept", 8'd100, 8'd7, 1'b0);
    endtask

    task automatic test_directed;
        check_op("dir_u_100_7", 8'd100, 8'd7, 1'b0);
        check_op("dir_s_m100_7", 8'h9C, 8'd7, 1'b1);
        check_op("dir_s_100_m7", 8'd100, 8'hF9, 1'b1);
        check_op("dir_s_37_0", 8'd37, 8'd0, 1'b1);
        check_op("dir_u_37_0", 8'd37, 8'd0, 1'b0);
        check_op("dir_s_min_m1", 8'h80, 8'hFF, 1'b1);
        check_op("dir_u_80_ff", 8'h80, 8'hFF, 1'b0);
        check_op("dir_s_m128_0", 8'h80, 8'h00, 1'b1);
        check_op("dir_u_255_1", 8'hFF, 8'h01, 1'b0);
        check_op("dir_s_m1_m128", 8'hFF, 8'h80, 1'b1);
    endtask

    task automatic test_random;
        logic [DW-1:0] ra, rb;
        logic rs;
        for (int i = 0; i < 60; i++) begin
            ra = DW'($urandom_range(255));
            rb = DW'($urandom_range(255));
            rs = 1'($urandom_range(1));
            case ($urandom_range(7))
                0: rb = 8'h00;
                1: rb = 8'hFF;
                2: ra = 8'h80;
                default: ;
            endcase
            check_op("random", ra, rb, rs);
        end
    endtask

    task automatic test_backpressure;
        logic [DW-1:0] eq, er;
        int elat;
        int guard;
        model(8'd100, 8'd7, 1'b0, eq, er, elat);
        a = 8'd100; b = 8'd7; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        guard = 0;
        while (!out_valid && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        total++;
        if (!out_valid) begin bad++; $display("FAIL bp_reach_done: got %b expected 1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            a = DW'($urandom_range(255));
            b = DW'($urandom_range(1, 255));
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold_flags cycle %0d: got valid=%b ready=%b expected valid=1 ready=0", i, out_valid, in_ready);
            end
            total++;
            if (quotient !== eq || remainder !== er) begin
                bad++;
                $display("FAIL bp_hold_data cycle %0d: got %h/%h expected %h/%h", i, quotient, remainder, eq, er);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_return_idle: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
        end
        check_op("bp_next_200_13", 8'd200, 8'd13, 1'b0);
    endtask

    task automatic watch_quiet(input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL %s: got %0d valid cycles expected 0", name, seen); end
    endtask

    task automatic test_flush;
        a = 8'd200; b = 8'd7; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_calc: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
        end
        watch_quiet("flush_calc_quiet");
        check_op("flush_next_9_3", 8'd9, 8'd3, 1'b0);
        // Flush in DONE with out_ready low, and flush beating a simultaneous accept.
        a = 8'd5; b = 8'd0; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_done: got %b expected 0", out_valid); end
        in_valid = 1'b1; a = 8'd9; b = 8'd0;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_over_accept: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid;
        a = 8'd200; b = 8'd7; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_state: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
        end
        total++;
        if (quotient !== '0 || remainder !== '0) begin
            bad++;
            $display("FAIL rst_mid_data: got %h/%h expected 00/00", quotient, remainder);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        watch_quiet("rst_mid_quiet");
        check_op("rst_next_9_3", 8'd9, 8'd3, 1'b0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        is_signed = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL have parameter: div_size, 8, operand/result width in bits (>=2).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  operands and is_signed valid this cycle.
REQ-005 SHALL have port: in_ready  output  1  divider can accept operands.
REQ-006 SHALL have port: a  input  div_size  dividend.
REQ-007 SHALL have port: b  input  div_size  divisor.
REQ-008 SHALL have port: is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 SHALL have port: flush  input  1  synchronous abort of any operation in flight.
REQ-010 SHALL have port: out_valid  output  1  quotient/remainder valid.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port: quotient  output  div_size  a / b, truncated toward zero.
REQ-013 SHALL have port: remainder  output  div_size  a - b*quotient; sign follows a.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 SHALL accept operands on a rising edge with in_valid=1 and in_ready=1 (acceptance cycle N); inputs are ignored in other states.
REQ-017 SHALL, on acceptance with signed operands, latch magnitudes |a|, |b|, plus quotient sign (a_msb XOR b_msb) and remainder sign (a_msb); unsigned operands are latched unchanged with both signs 0.
REQ-018 SHALL, in CALC, perform one restoring shift-subtract step per cycle (partial remainder width div_size+1), producing one quotient bit MSB-first, using an iteration counter 0..div_size-1.
REQ-019 SHALL transition CALC -> DONE after exactly div_size CALC cycles, so out_valid first asserts in cycle N+div_size+1.
REQ-020 SHALL apply sign correction (two's-complement negate of quotient and/or remainder) when entering DONE and register the results; no combinational path from a/b to quotient/remainder.
REQ-021 SHALL, for b == 0, go IDLE -> DONE directly with quotient = all ones and remainder = a (unmodified), out_valid in cycle N+1, for both signed and unsigned.
REQ-022 SHALL, for is_signed=1, a = most negative value, b = all ones (-1), go IDLE -> DONE directly with quotient = a and remainder = 0, out_valid in cycle N+1.
REQ-023 SHALL hold out_valid, quotient and remainder stable in DONE while out_ready=0.
REQ-024 SHALL transition DONE -> IDLE on the edge where out_ready=1; in_ready is 1 the following cycle (no same-cycle accept/return).
REQ-025 SHALL, with flush=1 on a rising edge in any state, go to IDLE, clear the counter and deassert out_valid next cycle; flush has priority over acceptance, iteration and out_ready.
REQ-026 SHALL keep quotient and remainder outputs unchanged outside DONE except at reset (value is don't-care to consumers when out_valid=0).

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force state IDLE, counter 0, quotient 0, remainder 0, out_valid 0, in_ready 1 after release.
REQ-028 SHALL, on reset asserted mid-CALC or in DONE, discard the operation; no result is produced after reset release.
REQ-029 SHALL accept a new operation on the first rising edge after rst_n deasserts if in_valid=1.

Verification (div_size=8)
REQ-030 SHALL verify unsigned a=100, b=7 accepted cycle N -> out_valid cycle N+9, quotient=14 (0x0E), remainder=2.
REQ-031 SHALL verify signed a=0x9C (-100), b=7 -> quotient=0xF2 (-14), remainder=0xFE (-2), cycle N+9; and a=100, b=0xF9 (-7) -> quotient=0xF2, remainder=0x02.
REQ-032 SHALL verify a=37, b=0 (signed and unsigned) -> quotient=0xFF, remainder=37, out_valid cycle N+1.
REQ-033 SHALL verify signed a=0x80, b=0xFF -> quotient=0x80, remainder=0x00, out_valid cycle N+1.
REQ-034 SHALL verify out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next cycle, next operation then 200/13 -> quotient 15, remainder 5.
REQ-035 SHALL verify flush=1 at CALC iteration 3 and rst_n=0 at CALC iteration 5 (separate runs) -> IDLE next cycle / immediately, out_valid never asserts for aborted operation, following 9/3 -> quotient 3, remainder 0.
